screen_compositor: RTL and testbench
====================================

Name: screen_compositor

Overview:
- Parametrised pixel compositor between the DVI timing controller and the DVI output pins.
- Merges N priority-ordered sprite layers (player, bullets, enemies, ...) over a background colour.
- Overlays loadable LOSE/WIN banner bitmaps with frame-based blinking, and dims the scene in PAUSE.
- Registers RGB together with hsync/vsync/de so pixel data and sync stay aligned at a fixed latency.

Parameters:
- layers_p, 4, number of sprite layers; index 0 has highest priority.
- color_width_p, 4, bits per colour channel.
- coord_width_p, 10, width of sx_i/sy_i.
- bmap_cols_p, 20, banner bitmap columns.
- bmap_rows_p, 15, banner bitmap rows.
- bmap_shift_p, 5, log2 of banner cell size in pixels.
- blink_frames_p, 30, frames per blink half-period (>=1).
- lose_color_p, 12'hF00, banner colour in LOSE ({R,G,B}, 3*color_width_p bits).
- win_color_p, 12'h5E5, banner colour in WIN.

Ports:
- clk_i  in  1  pixel clock.
- reset_n_async_unsafe_i  in  1  asynchronous active-low reset.
- sx_i  in  coord_width_p  current pixel x.
- sy_i  in  coord_width_p  current pixel y.
- de_i  in  1  display enable.
- hsync_i  in  1  horizontal sync.
- vsync_i  in  1  vertical sync.
- frame_i  in  1  one-cycle pulse per frame, during blanking.
- mode_i  in  2  requested mode: 0 PLAY, 1 LOSE, 2 WIN, 3 PAUSE.
- layer_valid_i  in  layers_p  layer i covers the current pixel.
- layer_rgb_i  in  layers_p*3*color_width_p  packed {R,G,B} per layer; layer 0 in the LSBs.
- bg_rgb_i  in  3*color_width_p  background colour.
- bmap_wr_valid_i  in  1  bitmap row write strobe.
- bmap_wr_sel_i  in  1  0 = LOSE bitmap, 1 = WIN bitmap.
- bmap_wr_row_i  in  $clog2(bmap_rows_p)  row address.
- bmap_wr_data_i  in  bmap_cols_p  row bits; bit 0 = leftmost column.
- hsync_o  out  1  hsync_i delayed 2 cycles.
- vsync_o  out  1  vsync_i delayed 2 cycles.
- de_o  out  1  de_i delayed 2 cycles.
- r_o  out  color_width_p  red channel.
- g_o  out  color_width_p  green channel.
- b_o  out  color_width_p  blue channel.
- mode_o  out  2  currently active (latched) mode.
- blink_on_o  out  1  current blink phase.

Behaviour:
- Reset (asynchronous, active-low):
  - all outputs 0; mode_o = PLAY; blink_on_o = 1; blink counter 0;
  - both bitmaps cleared to 0; pipeline registers cleared.
  - Deasserting reset mid-frame gives no special resync; outputs are valid 2 cycles after the first sampled input.
- Mode latch:
  - mode_o loads mode_i only on a cycle with frame_i = 1; it never changes mid-frame.
  - If the loaded value differs from the current mode: blink counter -> 0, blink_on_o -> 1.
- Blink:
  - In LOSE/WIN, the counter increments on each frame_i.
  - When it reaches blink_frames_p-1 and frame_i is seen, it returns to 0 and blink_on_o toggles.
  - In PLAY/PAUSE, counter held at 0 and blink_on_o = 1.
  - A mode change on the same frame_i takes precedence over the counter increment.
- Pipeline, fixed latency 2 for every output:
  - Stage 1 registers sx/sy-derived cell indices, de, syncs, layer inputs, bg_rgb_i and mode, and reads the addressed bitmap row word.
  - Stage 2 selects the pixel and registers RGB and syncs.
- Pixel select, evaluated in stage 2:
  - de = 0 -> RGB = 0.
  - PLAY: lowest-index layer i with valid = 1 supplies RGB; no valid layer -> bg_rgb_i.
  - PAUSE: the PLAY result with each channel logically shifted right by 1 (F -> 7).
  - LOSE: cell bit = 1 and blink_on_o = 1 -> lose_color_p; otherwise 0.
  - WIN: as LOSE, using the WIN bitmap and win_color_p.
  - Cell index: col = sx >> bmap_shift_p, row = sy >> bmap_shift_p. col >= bmap_cols_p or row >= bmap_rows_p -> bit 0 (no wrap, no aliasing).
- Bitmap write:
  - Takes effect at the clock edge.
  - A same-cycle read of the written row returns the old contents (read-before-write).
  - Out-of-range row writes are ignored.
  - Writes are accepted in any mode.
- Width rules:
  - No arithmetic overflow is possible: shifts only, and the counter is $clog2(blink_frames_p)+1 bits.
  - Sync signals pass through without polarity change.

Decomposition:
- Package screen_pkg:
  - mode_e enum (MODE_PLAY = 2'd0, MODE_LOSE, MODE_WIN, MODE_PAUSE);
  - rgb_t struct parameterised by color_width_p via localparam;
  - default colour constants.
- Sub-module layer_priority_mux: combinational priority select across layers_p layers, returning RGB and a hit flag.
- The bitmap store is a register array inside the top block, not a RAM macro.

Test Plan:
- Reset, then drive de = 1, layers 1 and 2 valid (0x0F0, 0x00F), mode PLAY -> two cycles later RGB = 0x0F0; no layer valid -> bg_rgb_i.
- mode_i = LOSE mid-frame -> mode_o stays PLAY until frame_i, then LOSE; same-cycle pixel change happens only after the pulse.
- Write LOSE row 3 = bit 5 set; in LOSE drive sx = 160..191, sy = 96..127 -> RGB = 0xF00; sx = 192 -> 0; sx = 700 (col 21) -> 0.
- blink_frames_p = 2 in LOSE -> blink_on_o toggles every 2 frame_i pulses; banner pixel is 0 while off; switching to WIN forces blink_on_o = 1.
- PAUSE with layer 0 = 0xFA4 -> RGB = 0x752; de = 0 -> 0x000; hsync/vsync/de_o equal inputs delayed exactly 2 cycles.
- Assert reset mid-line with mode WIN and banner loaded -> outputs 0 immediately, mode_o = PLAY, and the banner reads all 0 after release.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types and constants for the screen compositor: mode encoding,
// the default colour format and the stock banner colours.
package screen_pkg;

    localparam int color_width_c = 4;

    typedef enum logic [1:0] {
        MODE_PLAY  = 2'd0,
        MODE_LOSE  = 2'd1,
        MODE_WIN   = 2'd2,
        MODE_PAUSE = 2'd3
    } mode_e;

    typedef struct packed {
        logic [color_width_c-1:0] r;
        logic [color_width_c-1:0] g;
        logic [color_width_c-1:0] b;
    } rgb_t;

    localparam rgb_t black_c      = 12'h000;
    localparam rgb_t lose_color_c = 12'hF00;
    localparam rgb_t win_color_c  = 12'h5E5;

endpackage

// File: rtl/screen_compositor_layer_priority_mux.sv
// Priority select across sprite layers; the lowest-index valid layer wins.
module layer_priority_mux #(
    parameter int layers_p      = 4,
    parameter int color_width_p = 4
) (
    input  logic [layers_p-1:0]                 valid,
    input  logic [layers_p*3*color_width_p-1:0] rgb_in,
    output logic [3*color_width_p-1:0]          rgb,
    output logic                                hit
);

    localparam int rgb_w = 3 * color_width_p;

    // Walk from the lowest priority upward so layer 0 is written last.
    always_comb begin
        rgb = '0;
        hit = 1'b0;
        for (int i = layers_p - 1; i >= 0; i--) begin
            if (valid[i]) begin
                rgb = rgb_in[i*rgb_w +: rgb_w];
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/screen_compositor.sv
// Pixel compositor: sprite layers over background, LOSE/WIN banner bitmaps
// with frame-based blinking, PAUSE dimming; fixed 2-cycle latency.
module screen_compositor
    import screen_pkg::*;
#(
    parameter int layers_p       = 4,
    parameter int color_width_p  = color_width_c,
    parameter int coord_width_p  = 10,
    parameter int bmap_cols_p    = 20,
    parameter int bmap_rows_p    = 15,
    parameter int bmap_shift_p   = 5,
    parameter int blink_frames_p = 30,
    parameter logic [3*color_width_p-1:0] lose_color_p = lose_color_c,
    parameter logic [3*color_width_p-1:0] win_color_p  = win_color_c
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_async_unsafe_i,
    input  logic [coord_width_p-1:0]             sx_i,
    input  logic [coord_width_p-1:0]             sy_i,
    input  logic                                 de_i,
    input  logic                                 hsync_i,
    input  logic                                 vsync_i,
    input  logic                                 frame_i,
    input  logic [1:0]                           mode_i,
    input  logic [layers_p-1:0]                  layer_valid_i,
    input  logic [layers_p*3*color_width_p-1:0]  layer_rgb_i,
    input  logic [3*color_width_p-1:0]           bg_rgb_i,
    input  logic                                 bmap_wr_valid_i,
    input  logic                                 bmap_wr_sel_i,
    input  logic [$clog2(bmap_rows_p)-1:0]       bmap_wr_row_i,
    input  logic [bmap_cols_p-1:0]               bmap_wr_data_i,
    output logic                                 hsync_o,
    output logic                                 vsync_o,
    output logic                                 de_o,
    output logic [color_width_p-1:0]             r_o,
    output logic [color_width_p-1:0]             g_o,
    output logic [color_width_p-1:0]             b_o,
    output logic [1:0]                           mode_o,
    output logic                                 blink_on_o
);

    // state      | meaning
    // MODE_PLAY  | sprites over background
    // MODE_LOSE  | blinking LOSE banner
    // MODE_WIN   | blinking WIN banner
    // MODE_PAUSE | PLAY picture at half intensity

    localparam int cell_w = coord_width_p - bmap_shift_p;
    localparam int row_w  = $clog2(bmap_rows_p);
    localparam int cnt_w  = $clog2(blink_frames_p) + 1;
    localparam int rgb_w  = 3 * color_width_p;

    mode_e             mode_q, mode_d;
    logic [cnt_w-1:0]  cnt_q, cnt_d;
    logic              blink_q, blink_d;

    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            mode_q  <= MODE_PLAY;
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (frame_i) begin
            if (mode_e'(mode_i) != mode_q) begin
                mode_d  = mode_e'(mode_i);
                cnt_d   = '0;
                blink_d = 1'b1;
            end else if (mode_q == MODE_LOSE || mode_q == MODE_WIN) begin
                if (cnt_q == cnt_w'(blink_frames_p - 1)) begin
                    cnt_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d   = '0;
                blink_d = 1'b1;
            end
        end
    end

    assign mode_o     = mode_q;
    assign blink_on_o = blink_q;

    logic [bmap_cols_p-1:0] lose_bmap [bmap_rows_p];
    logic [bmap_cols_p-1:0] win_bmap  [bmap_rows_p];

    // Row addresses with no matching entry (>= bmap_rows_p) write nothing.
    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            for (int r = 0; r < bmap_rows_p; r++) begin
                lose_bmap[r] <= '0;
                win_bmap[r]  <= '0;
            end
        end else if (bmap_wr_valid_i) begin
            for (int r = 0; r < bmap_rows_p; r++) begin
                if (bmap_wr_row_i == row_w'(r)) begin
                    if (bmap_wr_sel_i) win_bmap[r]  <= bmap_wr_data_i;
                    else               lose_bmap[r] <= bmap_wr_data_i;
                end
            end
        end
    end

    logic [cell_w-1:0]      row_idx, col_idx;
    logic [bmap_cols_p-1:0] row_word;

    assign row_idx = sy_i[coord_width_p-1:bmap_shift_p];
    assign col_idx = sx_i[coord_width_p-1:bmap_shift_p];

    always_comb begin
        row_word = '0;
        for (int r = 0; r < bmap_rows_p; r++) begin
            if (row_idx == cell_w'(r))
                row_word = (mode_q == MODE_WIN) ? win_bmap[r] : lose_bmap[r];
        end
    end

    logic [cell_w-1:0]           col_s1;
    logic [bmap_cols_p-1:0]      row_word_s1;
    logic                        de_s1, hsync_s1, vsync_s1;
    logic [layers_p-1:0]         valid_s1;
    logic [layers_p*rgb_w-1:0]   layer_rgb_s1;
    logic [rgb_w-1:0]            bg_s1;
    mode_e                       mode_s1;

    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            col_s1       <= '0;
            row_word_s1  <= '0;
            de_s1        <= 1'b0;
            hsync_s1     <= 1'b0;
            vsync_s1     <= 1'b0;
            valid_s1     <= '0;
            layer_rgb_s1 <= '0;
            bg_s1        <= '0;
            mode_s1      <= MODE_PLAY;
        end else begin
            col_s1       <= col_idx;
            row_word_s1  <= row_word;
            de_s1        <= de_i;
            hsync_s1     <= hsync_i;
            vsync_s1     <= vsync_i;
            valid_s1     <= layer_valid_i;
            layer_rgb_s1 <= layer_rgb_i;
            bg_s1        <= bg_rgb_i;
            mode_s1      <= mode_q;
        end
    end

    logic [rgb_w-1:0] mux_rgb, play_rgb, dim_rgb, pix_rgb;
    logic             mux_hit, cell_bit;

    layer_priority_mux #(
        .layers_p      (layers_p),
        .color_width_p (color_width_p)
    ) u_layer_mux (
        .valid  (valid_s1),
        .rgb_in (layer_rgb_s1),
        .rgb    (mux_rgb),
        .hit    (mux_hit)
    );

    always_comb begin
        cell_bit = 1'b0;
        for (int c = 0; c < bmap_cols_p; c++) begin
            if (col_s1 == cell_w'(c)) cell_bit = row_word_s1[c];
        end
        play_rgb = mux_hit ? mux_rgb : bg_s1;
        for (int ch = 0; ch < 3; ch++)
            dim_rgb[ch*color_width_p +: color_width_p] =
                play_rgb[ch*color_width_p +: color_width_p] >> 1;
        case (mode_s1)
            MODE_PLAY:  pix_rgb = play_rgb;
            MODE_PAUSE: pix_rgb = dim_rgb;
            MODE_LOSE:  pix_rgb = (cell_bit && blink_q) ? lose_color_p : '0;
            MODE_WIN:   pix_rgb = (cell_bit && blink_q) ? win_color_p  : '0;
            default:    pix_rgb = '0;
        endcase
        if (!de_s1) pix_rgb = '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            {r_o, g_o, b_o}  <= '0;
            de_o             <= 1'b0;
            hsync_o          <= 1'b0;
            vsync_o          <= 1'b0;
        end else begin
            {r_o, g_o, b_o}  <= pix_rgb;
            de_o             <= de_s1;
            hsync_o          <= hsync_s1;
            vsync_o          <= vsync_s1;
        end
    end

endmodule

// File: tb/tb_screen_compositor.sv
// Directed self-checking bench for screen_compositor (blink half-period of 2 frames).
module tb_screen_compositor;

    logic        clk_i = 1'b0;
    logic        reset_n_async_unsafe_i;
    logic [9:0]  sx_i, sy_i;
    logic        de_i, hsync_i, vsync_i, frame_i;
    logic [1:0]  mode_i;
    logic [3:0]  layer_valid_i;
    logic [47:0] layer_rgb_i;
    logic [11:0] bg_rgb_i;
    logic        bmap_wr_valid_i, bmap_wr_sel_i;
    logic [3:0]  bmap_wr_row_i;
    logic [19:0] bmap_wr_data_i;
    logic        hsync_o, vsync_o, de_o, blink_on_o;
    logic [3:0]  r_o, g_o, b_o;
    logic [1:0]  mode_o;
    logic [11:0] rgb;

    int total = 0;
    int bad   = 0;

    assign rgb = {r_o, g_o, b_o};

    screen_compositor #(.blink_frames_p(2)) dut (
        .clk_i                  (clk_i),
        .reset_n_async_unsafe_i (reset_n_async_unsafe_i),
        .sx_i                   (sx_i),
        .sy_i                   (sy_i),
        .de_i                   (de_i),
        .hsync_i                (hsync_i),
        .vsync_i                (vsync_i),
        .frame_i                (frame_i),
        .mode_i                 (mode_i),
        .layer_valid_i          (layer_valid_i),
        .layer_rgb_i            (layer_rgb_i),
        .bg_rgb_i               (bg_rgb_i),
        .bmap_wr_valid_i        (bmap_wr_valid_i),
        .bmap_wr_sel_i          (bmap_wr_sel_i),
        .bmap_wr_row_i          (bmap_wr_row_i),
        .bmap_wr_data_i         (bmap_wr_data_i),
        .hsync_o                (hsync_o),
        .vsync_o                (vsync_o),
        .de_o                   (de_o),
        .r_o                    (r_o),
        .g_o                    (g_o),
        .b_o                    (b_o),
        .mode_o                 (mode_o),
        .blink_on_o             (blink_on_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_frame(input logic [1:0] m);
        mode_i  = m;
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
        tick();
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        sx_i = x;
        sy_i = y;
        tick();
        tick();
    endtask

    task automatic bmap_write(input logic sel, input logic [3:0] row, input logic [19:0] data);
        bmap_wr_sel_i   = sel;
        bmap_wr_row_i   = row;
        bmap_wr_data_i  = data;
        bmap_wr_valid_i = 1'b1;
        tick();
        bmap_wr_valid_i = 1'b0;
    endtask

    logic [7:0] hpat, vpat, dpat;

    initial begin
        reset_n_async_unsafe_i = 1'b0;
        sx_i = '0; sy_i = '0; de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
        frame_i = 1'b0; mode_i = 2'd0; layer_valid_i = '0;
        layer_rgb_i = {12'h123, 12'h00F, 12'h0F0, 12'hAAA};
        bg_rgb_i = 12'h345;
        bmap_wr_valid_i = 1'b0; bmap_wr_sel_i = 1'b0; bmap_wr_row_i = '0; bmap_wr_data_i = '0;
        tick(); tick();
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_mode", mode_o, 2'd0);
        chk("reset_blink", blink_on_o, 1'b1);
        chk("reset_de", de_o, 1'b0);
        reset_n_async_unsafe_i = 1'b1;
        tick();

        // PLAY priority
        de_i = 1'b1;
        layer_valid_i = 4'b0110;
        pixel(10'd5, 10'd5);
        chk("play_l1_over_l2", rgb, 12'h0F0);
        layer_valid_i = 4'b0000;
        pixel(10'd5, 10'd5);
        chk("play_bg", rgb, 12'h345);
        layer_valid_i = 4'b1000;
        pixel(10'd5, 10'd5);
        chk("play_l3", rgb, 12'h123);
        layer_valid_i = 4'b0000;

        bmap_write(1'b0, 4'd3, 20'h00020);
        bmap_write(1'b0, 4'd15, 20'hFFFFF);

        // LOSE requested mid-frame: no effect until frame_i
        mode_i = 2'd1;
        pixel(10'd160, 10'd96);
        tick(); tick();
        chk("mode_hold", mode_o, 2'd0);
        chk("mode_hold_rgb", rgb, 12'h345);
        pulse_frame(2'd1);
        chk("mode_lose", mode_o, 2'd1);
        chk("lose_blink_init", blink_on_o, 1'b1);

        pixel(10'd160, 10'd96);
        chk("lose_cell_lo", rgb, 12'hF00);
        pixel(10'd191, 10'd127);
        chk("lose_cell_hi", rgb, 12'hF00);
        pixel(10'd192, 10'd100);
        chk("lose_col6", rgb, 12'h000);
        pixel(10'd700, 10'd100);
        chk("lose_col21", rgb, 12'h000);
        pixel(10'd160, 10'd480);
        chk("lose_row15", rgb, 12'h000);
        pixel(10'd160, 10'd95);
        chk("lose_row2", rgb, 12'h000);

        // read-before-write on row 2
        sx_i = 10'd170; sy_i = 10'd70;
        bmap_write(1'b0, 4'd2, 20'h00020);
        tick();
        chk("rbw_old", rgb, 12'h000);
        pixel(10'd170, 10'd70);
        chk("rbw_new", rgb, 12'hF00);

        // blink with half-period of 2 frames
        pulse_frame(2'd1);
        chk("blink_f1", blink_on_o, 1'b1);
        pulse_frame(2'd1);
        chk("blink_f2", blink_on_o, 1'b0);
        pixel(10'd160, 10'd96);
        chk("blink_off_rgb", rgb, 12'h000);
        pulse_frame(2'd1);
        chk("blink_f3", blink_on_o, 1'b0);
        pulse_frame(2'd1);
        chk("blink_f4", blink_on_o, 1'b1);
        pixel(10'd160, 10'd96);
        chk("blink_on_rgb", rgb, 12'hF00);
        pulse_frame(2'd1);
        pulse_frame(2'd1);
        chk("blink_f6", blink_on_o, 1'b0);

        // WIN forces blink on
        pulse_frame(2'd2);
        chk("win_mode", mode_o, 2'd2);
        chk("win_blink", blink_on_o, 1'b1);
        bmap_write(1'b1, 4'd0, 20'h00001);
        pixel(10'd0, 10'd0);
        chk("win_cell", rgb, 12'h5E5);
        pixel(10'd160, 10'd96);
        chk("win_not_lose_map", rgb, 12'h000);

        // PAUSE dimming
        pulse_frame(2'd3);
        chk("pause_mode", mode_o, 2'd3);
        layer_rgb_i[11:0] = 12'hFA4;
        layer_valid_i = 4'b0001;
        pixel(10'd5, 10'd5);
        chk("pause_dim", rgb, 12'h752);
        de_i = 1'b0;
        pixel(10'd5, 10'd5);
        chk("pause_de0", rgb, 12'h000);

        // sync pipeline delay of exactly 2
        hpat = 8'b1011_0010;
        vpat = 8'b0110_1100;
        dpat = 8'b1100_0101;
        for (int i = 0; i < 8; i++) begin
            hsync_i = hpat[i];
            vsync_i = vpat[i];
            de_i    = dpat[i];
            tick();
            if (i >= 1) begin
                chk("hsync_delay", hsync_o, hpat[i-1]);
                chk("vsync_delay", vsync_o, vpat[i-1]);
                chk("de_delay", de_o, dpat[i-1]);
            end
        end
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        de_i = 1'b1;

        // reset mid-line in WIN with banner loaded
        layer_valid_i = 4'b0000;
        pulse_frame(2'd2);
        pixel(10'd0, 10'd0);
        chk("win_before_reset", rgb, 12'h5E5);
        #2;
        reset_n_async_unsafe_i = 1'b0;
        #1;
        chk("async_rst_rgb", rgb, 12'h000);
        chk("async_rst_mode", mode_o, 2'd0);
        chk("async_rst_hsync", hsync_o, 1'b0);
        tick();
        reset_n_async_unsafe_i = 1'b1;
        tick();
        pulse_frame(2'd2);
        chk("post_rst_win", mode_o, 2'd2);
        pixel(10'd0, 10'd0);
        chk("post_rst_win_clear", rgb, 12'h000);
        pulse_frame(2'd1);
        pixel(10'd160, 10'd96);
        chk("post_rst_lose_clear", rgb, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
